uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into framed register-write commands.
- Frame format: SYNC, ADDR, LEN, LEN payload bytes, CSUM. The block buffers the payload and checks the checksum.
- Only a valid frame is committed, as a burst of writes over a valid/ready write port to the register bank.
- Sits directly after the UART receiver in the uart_clk domain.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame (power of 2, 2..256).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYCLES, 4096: maximum uart_clk cycles allowed between bytes inside a frame.

Ports:
- uart_clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- rx_data  input  8  received byte; stable from the rising edge of rx_data_ready until the next start bit.
- rx_data_ready  input  1  level from the receiver. It goes high when a byte completes and stays high until the next start bit.
- wr_en  output  1  write valid.
- wr_addr  output  8  write address.
- wr_data  output  8  write data.
- wr_ready  input  1  write accept; a transfer occurs when wr_en && wr_ready.
- frame_ok  output  1  1-cycle pulse after the last write of a frame is accepted.
- frame_err  output  1  1-cycle pulse when a frame is aborted.
- err_code  output  2  0=OVERRUN, 1=BAD_LEN, 2=BAD_CSUM, 3=TIMEOUT. Updated only on a frame_err pulse, held otherwise.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, frame_ok=0, frame_err=0, err_code=0, busy=0. State=IDLE, pending=0, timeout counter=0.
- Reset mid-frame or mid-commit aborts immediately with no error pulse.
- Byte strobe:
  - strobe = rx_data_ready && !rdy_q, where rdy_q is a registered copy of rx_data_ready.
  - rdy_q resets to 1, so a byte held across reset is ignored.
  - rx_data is sampled in the strobe cycle.
- Pending register:
  - A strobe is captured into a one-byte pending register (byte + valid). The FSM consumes it the following cycle in any state except COMMIT.
  - A strobe while pending is already valid: the byte is dropped, frame_err pulses with err_code=OVERRUN, and the FSM returns to IDLE with pending cleared.
- FSM states:
  - IDLE: a pending byte equal to SYNC_BYTE moves to ADDR. Any other byte is discarded silently.
  - ADDR: store base address; csum_acc = byte; move to LEN.
  - LEN:
    - byte==0 or byte>MAX_LEN: frame_err, err_code=BAD_LEN, go to IDLE.
    - Otherwise store len, add the byte to csum_acc, idx=0, move to PAYLOAD.
  - PAYLOAD: write the byte to buffer[idx]; add it to csum_acc; idx++. When idx reaches len, move to CSUM.
  - CSUM:
    - (csum_acc + byte) mod 256 == 0: go to COMMIT with idx=0.
    - Otherwise frame_err, err_code=BAD_CSUM, go to IDLE.
  - COMMIT:
    - Drive wr_en=1, wr_addr=(base+idx) mod 256, wr_data=buffer[idx].
    - On acceptance, idx++. After the len-th acceptance: wr_en=0, frame_ok pulses the next cycle, return to IDLE.
    - wr_addr/wr_data hold stable while wr_en && !wr_ready.
    - Strobes during COMMIT fill pending and are consumed in IDLE afterwards. A second strobe during COMMIT is OVERRUN: frame_err pulses, the commit burst completes unaffected, and pending is cleared.
- Checksum: 8-bit wrapping sum of ADDR, LEN, every payload byte and CSUM; the frame is valid when the sum is 0.
- Address wrap: base 8'hFE with len 4 writes FE, FF, 00, 01.
- Buffer read latency: 1 cycle (registered read). The first wr_en asserts 2 cycles after the CSUM byte is consumed.
- frame_ok and frame_err are never asserted in the same cycle; OVERRUN in the final commit cycle pulses frame_err one cycle before frame_ok.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - The counter resets on each consumed byte and counts in ADDR/LEN/PAYLOAD/CSUM.
  - On reaching TIMEOUT_CYCLES: frame_err, err_code=TIMEOUT, go to IDLE.
  - The counter does not run in IDLE or COMMIT.
- Undefined: no counter logic; the FSM waits indefinitely for the next byte.

Decomposition:
- Package uart_frame_pkg holds:
  - the state enum (IDLE, ADDR, LEN, PAYLOAD, CSUM, COMMIT);
  - the err_code enum (ERR_OVERRUN, ERR_BAD_LEN, ERR_BAD_CSUM, ERR_TIMEOUT);
  - the default SYNC_BYTE constant.
- Sub-module uart_frame_buf: MAX_LEN x 8 simple dual-port RAM with a synchronous write port and a registered read port.

Test Plan:
- Frame A5,10,02,11,22,BB (sum 0x10+0x02+0x11+0x22+0xBB=0x100) with wr_ready=1 -> writes (10,11),(11,22); frame_ok pulses once; no frame_err.
- Same frame with CSUM=BC -> no wr_en; frame_err with err_code=2.
- A5,FE,04, four bytes, correct CSUM; wr_ready low for 3 cycles on the 2nd write -> addresses FE,FF,00,01 in order; wr_addr/wr_data stable while stalled.
- LEN=0, then separately LEN=MAX_LEN+1 -> frame_err with err_code=1 each time; a following valid frame commits correctly.
- Garbage bytes 00,FF,5A before SYNC -> silently discarded; next frame commits. Two strobes during COMMIT -> frame_err with err_code=0, burst still completes.
- With UART_FRAME_TIMEOUT_EN: stop after the LEN byte for TIMEOUT_CYCLES cycles -> frame_err with err_code=3, busy falls. Without the macro: busy stays high and the frame completes when bytes resume.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types for the UART frame controller.
// Holds the FSM state, the error codes and the default sync marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    PAYLOAD,
    CSUM,
    COMMIT
  } state_t;

  typedef enum logic [1:0] {
    ERR_OVERRUN,
    ERR_BAD_LEN,
    ERR_BAD_CSUM,
    ERR_TIMEOUT
  } err_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload buffer, one write port and one read port.
// Reads are registered; rdata holds while re is low.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // store payload bytes as they arrive
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read feeding the write port data
  always_ff @(posedge clk) begin
    if (reset)   rdata <= 8'h00;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frames UART bytes into register-write bursts.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic       uart_clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_ready,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int         AW   = $clog2(MAX_LEN);
  localparam int         LW   = AW + 1;
  localparam logic [8:0] MAX9 = 9'(MAX_LEN);

  if (MAX_LEN < 2 || MAX_LEN > 256 ||
      (MAX_LEN & (MAX_LEN - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("uart_rx_frame_ctrl: bad parameter");
  end

  state_t        state;
  state_t        state_n;
  logic          rdy_q;
  logic          strobe;
  logic          pend_vld;
  logic [7:0]    pend_byte;
  logic          overrun;
  logic          consume;
  logic [7:0]    base;
  logic [7:0]    csum_acc;
  logic [7:0]    csum_sum;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic          bad_len;
  logic          csum_ok;
  logic          pl_last;
  logic          accept;
  logic          last_acc;
  logic          issue;
  logic          buf_we;
  logic          timeout;
  logic          err_set;
  err_t          err_val;
  logic          ok_set;
  logic          ok_hold;

  assign strobe   = rx_data_ready && !rdy_q;
  assign overrun  = strobe && pend_vld;
  assign consume  = pend_vld && !overrun &&
                    (state != COMMIT);
  assign bad_len  = (pend_byte == 8'd0) ||
                    ({1'b0, pend_byte} > MAX9);
  assign csum_sum = csum_acc + pend_byte;
  assign csum_ok  = (csum_sum == 8'd0);
  assign pl_last  = ((idx + LW'(1)) == len_q);
  assign accept   = wr_en && wr_ready;
  assign last_acc = (state == COMMIT) && accept &&
                    (idx == len_q);
  assign busy     = (state != IDLE);

  // previous rx_data_ready level; starts high so a held byte is ignored
  always_ff @(posedge uart_clk) begin
    if (reset) rdy_q <= 1'b1;
    else       rdy_q <= rx_data_ready;
  end

  // one-byte holding register between receiver and FSM
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      pend_vld  <= 1'b0;
      pend_byte <= 8'h00;
    end else if (overrun) begin
      pend_vld  <= 1'b0;
    end else if (strobe) begin
      pend_vld  <= 1'b1;
      pend_byte <= rx_data;
    end else if (consume) begin
      pend_vld  <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge uart_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (consume && pend_byte == SYNC_BYTE)
          state_n = ADDR;
      end
      ADDR: begin
        if (consume) state_n = LEN;
      end
      LEN: begin
        if (consume) begin
          if (bad_len) state_n = IDLE;
          else         state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (consume && pl_last) state_n = CSUM;
      end
      CSUM: begin
        if (consume) begin
          if (csum_ok) state_n = COMMIT;
          else         state_n = IDLE;
        end
      end
      COMMIT: begin
        if (last_acc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
    if (overrun && state != COMMIT) state_n = IDLE;
  end

  // FSM control outputs: error select, buffer and read strobes
  always_comb begin
    err_set = 1'b0;
    err_val = ERR_OVERRUN;
    if (overrun) begin
      err_set = 1'b1;
    end else if (consume && state == LEN && bad_len) begin
      err_set = 1'b1;
      err_val = ERR_BAD_LEN;
    end else if (consume && state == CSUM && !csum_ok) begin
      err_set = 1'b1;
      err_val = ERR_BAD_CSUM;
    end else if (timeout) begin
      err_set = 1'b1;
      err_val = ERR_TIMEOUT;
    end
    ok_set = last_acc;
    buf_we = consume && (state == PAYLOAD);
    issue  = (state == COMMIT) && (idx != len_q) &&
             (!wr_en || wr_ready);
  end

  // header fields, running checksum and byte index
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      base     <= 8'h00;
      csum_acc <= 8'h00;
      len_q    <= '0;
      idx      <= '0;
    end else if (issue) begin
      idx <= idx + LW'(1);
    end else if (consume) begin
      case (state)
        ADDR: begin
          base     <= pend_byte;
          csum_acc <= pend_byte;
        end
        LEN: begin
          len_q    <= LW'(pend_byte);
          csum_acc <= csum_sum;
          idx      <= '0;
        end
        PAYLOAD: begin
          csum_acc <= csum_sum;
          idx      <= idx + LW'(1);
        end
        CSUM:    idx <= '0;
        default: ;
      endcase
    end
  end

  // write port: a new beat loads as the previous one is taken
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= 8'h00;
    end else if (issue) begin
      wr_en   <= 1'b1;
      wr_addr <= base + 8'(idx);
    end else if (accept) begin
      wr_en   <= 1'b0;
    end
  end

  // status pulses; frame_ok slips a cycle if it meets an error pulse
  always_ff @(posedge uart_clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      frame_ok  <= 1'b0;
      ok_hold   <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      frame_err <= err_set;
      frame_ok  <= (ok_set && !err_set) || ok_hold;
      ok_hold   <= ok_set && err_set;
      if (err_set) err_code <= err_val;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          t_run;

  assign t_run   = (state == ADDR) || (state == LEN) ||
                   (state == PAYLOAD) || (state == CSUM);
  assign timeout = t_run && !consume && !overrun &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // idle cycles since the last consumed byte inside a frame
  always_ff @(posedge uart_clk) begin
    if (reset || !t_run || consume) tcnt <= '0;
    else                            tcnt <= tcnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (uart_clk),
    .reset (reset),
    .we    (buf_we),
    .waddr (idx[AW-1:0]),
    .wdata (pend_byte),
    .re    (issue),
    .raddr (idx[AW-1:0]),
    .rdata (wr_data)
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random frames against a frame model.
// Timeout steps follow UART_FRAME_TIMEOUT_EN.
module tb_uart_rx_frame_ctrl;

  localparam int         MAXL = 16;
  localparam int         TMO  = 64;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       uart_clk      = 1'b0;
  logic       reset         = 1'b1;
  logic [7:0] rx_data       = 8'hA5;
  logic       rx_data_ready = 1'b1;
  logic       wr_ready      = 1'b1;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] got_q[$];
  int          ok_cnt     = 0;
  int          err_cnt    = 0;
  int          both_cnt   = 0;
  int          stall_cyc  = 0;
  int          stall_viol = 0;
  int          acc_cnt    = 0;
  logic [1:0]  last_err   = 2'd0;
  logic        prev_stall = 1'b0;
  logic [7:0]  p_addr     = 8'h00;
  logic [7:0]  p_data     = 8'h00;

  int rdy_mode   = 0;
  int acc_base   = 0;
  int stall_used = 0;

  logic [7:0]  frm[$];
  logic [15:0] exp_w[$];
  int          exp_ok;
  int          exp_err;
  int          exp_code;
  int          ok0;
  int          err0;
  int          rd_ptr;

  uart_rx_frame_ctrl #(
    .MAX_LEN        (MAXL),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .uart_clk      (uart_clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 uart_clk = ~uart_clk;

  always @(posedge uart_clk) begin
    #1;
    if (rdy_mode == 0)
      wr_ready = 1'b1;
    else if (rdy_mode == 1)
      wr_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 3)
      wr_ready = 1'b0;
    else if (wr_en && (acc_cnt - acc_base) == 1 &&
             stall_used < 3) begin
      wr_ready = 1'b0;
      stall_used++;
    end else
      wr_ready = 1'b1;
    if (rdy_mode != 2) stall_used = 0;
  end

  always @(negedge uart_clk) begin
    if (wr_en && wr_ready) begin
      got_q.push_back({wr_addr, wr_data});
      acc_cnt++;
    end
    if (wr_en && !wr_ready) stall_cyc++;
    if (prev_stall && (!wr_en || wr_addr != p_addr ||
                       wr_data != p_data))
      stall_viol++;
    prev_stall = wr_en && !wr_ready;
    p_addr     = wr_addr;
    p_data     = wr_data;
    if (frame_ok) ok_cnt++;
    if (frame_err) begin
      err_cnt++;
      last_err = err_code;
    end
    if (frame_ok && frame_err) both_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs,
                     input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_ready = 1'b1;
    tick(3);
    rx_data_ready = 1'b0;
    tick(2);
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic build(input logic [7:0] base, input int len,
                       input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    frm.delete();
    frm.push_back(SYNC);
    frm.push_back(base);
    frm.push_back(8'(len));
    if (len == 0 || len > MAXL) return;
    s = base + 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      s = s + b;
    end
    b = 8'h00 - s;
    if (bad) b = b ^ 8'h5A;
    frm.push_back(b);
  endtask

  task automatic model();
    int         len;
    logic [7:0] s;
    exp_w.delete();
    exp_ok   = 0;
    exp_err  = 0;
    exp_code = 0;
    len = int'(frm[2]);
    if (len == 0 || len > MAXL) begin
      exp_err  = 1;
      exp_code = 1;
      return;
    end
    s = 8'h00;
    for (int i = 1; i < frm.size(); i++) s = s + frm[i];
    if (s != 8'h00) begin
      exp_err  = 1;
      exp_code = 2;
      return;
    end
    exp_ok = 1;
    for (int i = 0; i < len; i++)
      exp_w.push_back({8'(int'(frm[1]) + i), frm[3+i]});
  endtask

  task automatic start();
    ok0    = ok_cnt;
    err0   = err_cnt;
    rd_ptr = got_q.size();
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy || wr_en) && t < 3000) begin
      tick(1);
      t++;
    end
    chk({tag, ":idle_wait"}, int'(t < 3000), 1);
    tick(3);
  endtask

  task automatic finish_chk(input string tag);
    chk({tag, ":ok"}, ok_cnt - ok0, exp_ok);
    chk({tag, ":err"}, err_cnt - err0, exp_err);
    if (exp_err != 0)
      chk({tag, ":code"}, int'(last_err), exp_code);
    chk({tag, ":nwr"}, got_q.size() - rd_ptr, exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      if (rd_ptr + i < got_q.size())
        chk({tag, ":wr"}, int'(got_q[rd_ptr+i]),
            int'(exp_w[i]));
  endtask

  task automatic run(input string tag);
    model();
    start();
    send_frame();
    wait_idle(tag);
    finish_chk(tag);
  endtask

  initial begin
    int         t;
    int         r;
    int         len;
    logic [7:0] g;

    tick(3);
    chk("rst:wr_en", wr_en, 0);
    chk("rst:wr_addr", wr_addr, 0);
    chk("rst:wr_data", wr_data, 0);
    chk("rst:frame_ok", frame_ok, 0);
    chk("rst:frame_err", frame_err, 0);
    chk("rst:err_code", err_code, 0);
    chk("rst:busy", busy, 0);
    reset = 1'b0;
    tick(6);
    chk("rst:held_byte_busy", busy, 0);
    chk("rst:held_byte_err", err_cnt, 0);
    rx_data_ready = 1'b0;
    tick(2);

    frm = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB};
    run("basic");
    chk("basic:wr0", int'(got_q[rd_ptr]), 16'h1011);

    frm = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBC};
    run("badcsum");

    build(8'hFE, 4, 1'b0);
    model();
    start();
    t        = stall_cyc;
    acc_base = acc_cnt;
    rdy_mode = 2;
    send_frame();
    wait_idle("wrap");
    finish_chk("wrap");
    chk("wrap:stall_cycles", stall_cyc - t, 3);
    chk("wrap:stable", stall_viol, 0);
    rdy_mode = 0;

    build(8'h33, 0, 1'b0);
    run("len0");
    build(8'h33, MAXL + 1, 1'b0);
    run("lenmax1");
    build(8'h80, MAXL, 1'b0);
    run("lenmax");

    start();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    tick(4);
    chk("garbage:busy", busy, 0);
    chk("garbage:err", err_cnt - err0, 0);
    build(8'h44, 3, 1'b0);
    run("after_garbage");

    build(8'h40, 4, 1'b0);
    model();
    exp_err  = 1;
    exp_code = 0;
    start();
    rdy_mode = 3;
    send_frame();
    t = 0;
    while (!wr_en && t < 100) begin
      tick(1);
      t++;
    end
    chk("ovr:wr_en", wr_en, 1);
    send_byte(SYNC);
    send_byte(SYNC);
    rdy_mode = 0;
    wait_idle("ovr");
    finish_chk("ovr");
    chk("ovr:pend_cleared", busy, 0);

    build(8'h20, 2, 1'b0);
    model();
    start();
    for (int i = 0; i < 3; i++) send_byte(frm[i]);
`ifdef UART_FRAME_TIMEOUT_EN
    t = 0;
    while (err_cnt == err0 && t < TMO + 50) begin
      tick(1);
      t++;
    end
    tick(2);
    chk("tmo:err", err_cnt - err0, 1);
    chk("tmo:code", int'(last_err), 3);
    chk("tmo:busy", busy, 0);
    chk("tmo:nwr", got_q.size() - rd_ptr, 0);
`else
    tick(TMO * 3);
    chk("notmo:busy", busy, 1);
    chk("notmo:err", err_cnt - err0, 0);
    for (int i = 3; i < frm.size(); i++) send_byte(frm[i]);
    wait_idle("notmo");
    finish_chk("notmo");
`endif

    build(8'h55, 6, 1'b0);
    start();
    for (int i = 0; i < 5; i++) send_byte(frm[i]);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("midrst:busy", busy, 0);
    chk("midrst:err", err_cnt - err0, 0);
    build(8'h66, 5, 1'b0);
    run("after_rst");

    rdy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      g = 8'($urandom_range(0, 255));
      if (g == SYNC) g = 8'h00;
      if ((n % 3) == 0) send_byte(g);
      r = $urandom_range(0, 9);
      if (r == 0)
        len = ($urandom_range(0, 1) != 0) ? 0 :
              MAXL + 1 + $urandom_range(0, 200);
      else
        len = $urandom_range(1, MAXL);
      build(8'($urandom), len, r == 1);
      run("rnd");
    end
    rdy_mode = 0;
    tick(4);
    chk("rnd:stable", stall_viol, 0);
    chk("ok_err_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
